// File: rtl/adder_sequencer_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// FSM encoding, slice width and requester identifiers.
package adder_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/adder_sequencer_ripple_four.sv
// 4-bit ripple-carry adder slice with bit-level ports.
// Purely combinational; one full adder per bit.
module ripple_four (
  input  logic i_a0,
  input  logic i_a1,
  input  logic i_a2,
  input  logic i_a3,
  input  logic i_b0,
  input  logic i_b1,
  input  logic i_b2,
  input  logic i_b3,
  input  logic i_cin,
  output logic o_s0,
  output logic o_s1,
  output logic o_s2,
  output logic o_s3,
  output logic o_cout
);

  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [3:0] w_s;
  logic [4:0] w_c;

  assign w_a = {i_a3, i_a2, i_a1, i_a0};
  assign w_b = {i_b3, i_b2, i_b1, i_b0};
  assign w_c[0] = i_cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign w_s[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
    assign w_c[i+1] = (w_a[i] & w_b[i]) |
                      (w_c[i] & (w_a[i] ^ w_b[i]));
  end

  assign o_s0   = w_s[0];
  assign o_s1   = w_s[1];
  assign o_s2   = w_s[2];
  assign o_s3   = w_s[3];
  assign o_cout = w_c[4];

endmodule

// File: rtl/adder_sequencer.sv
// Two-port round-robin adder controller; computes a wide sum
// one nibble per cycle through a single shared 4-bit slice.
module adder_sequencer
  import adder_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [SLICE_W*NIBBLES-1:0] req0_a,
  input  logic [SLICE_W*NIBBLES-1:0] req0_b,
  input  logic                       req0_cin,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [SLICE_W*NIBBLES-1:0] req1_a,
  input  logic [SLICE_W*NIBBLES-1:0] req1_b,
  input  logic                       req1_cin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [SLICE_W*NIBBLES-1:0] rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_id
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  state_t         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_sum;
  logic           r_carry;
  logic [CW-1:0]  r_cnt;
  logic           r_id;
  logic           r_last;
  logic           r_valid;

  logic           w_idle;
  logic           w_gnt0;
  logic           w_gnt1;
  logic [3:0]     w_s;
  logic           w_co;
  logic [W-1:0]   w_ins;

  // Ready depends only on state, valids and last grant.
  assign w_idle = (r_state == S_IDLE) & ~rst;
  assign w_gnt0 = req0_valid &
                  (~req1_valid | (r_last == REQ_ID1));
  assign w_gnt1 = req1_valid &
                  (~req0_valid | (r_last == REQ_ID0));

  assign req0_ready = w_idle & w_gnt0;
  assign req1_ready = w_idle & w_gnt1;

  ripple_four u_slice (
    .i_a0   (r_a[0]),
    .i_a1   (r_a[1]),
    .i_a2   (r_a[2]),
    .i_a3   (r_a[3]),
    .i_b0   (r_b[0]),
    .i_b1   (r_b[1]),
    .i_b2   (r_b[2]),
    .i_b3   (r_b[3]),
    .i_cin  (r_carry),
    .o_s0   (w_s[0]),
    .o_s1   (w_s[1]),
    .o_s2   (w_s[2]),
    .o_s3   (w_s[3]),
    .o_cout (w_co)
  );

  // Slice result enters at the top of the sum register.
  assign w_ins = W'(w_s) << (W - SLICE_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_id    <= REQ_ID0;
      r_last  <= REQ_ID1;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req0_valid | req1_valid) begin
            r_a     <= w_gnt1 ? req1_a : req0_a;
            r_b     <= w_gnt1 ? req1_b : req0_b;
            r_carry <= w_gnt1 ? req1_cin : req0_cin;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum   <= (r_sum >> SLICE_W) | w_ins;
          r_a     <= r_a >> SLICE_W;
          r_b     <= r_b >> SLICE_W;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(NIBBLES - 1)) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_carry;
  assign rsp_id    = r_id;

endmodule

// File: tb/tb_adder_sequencer.sv
// Directed and randomized checks for adder_sequencer.
// Inputs driven 1ns after posedge, outputs sampled before the next edge.
module tb_adder_sequencer;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [W-1:0] rsp_sum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_sequencer #(.NIBBLES(NIB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Presents one request and waits for its acceptance edge.
  task automatic issue(input bit port, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin,
                       output int waited, output bit to);
    waited = 0;
    to = 1'b0;
    if (port) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    forever begin
      #1;
      if ((port ? req1_ready : req0_ready) === 1'b1) begin
        @(posedge clk); #1;
        if (port) req1_valid = 0; else req0_valid = 0;
        return;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 60) begin
        to = 1'b1;
        if (port) req1_valid = 0; else req0_valid = 0;
        return;
      end
    end
  endtask

  // Waits for rsp_valid, captures it and completes the handshake.
  task automatic get_rsp(output logic [W-1:0] s, output logic c,
                         output logic id, output int lat,
                         output bit to);
    lat = 1;
    to = 1'b0;
    rsp_ready = 1'b1;
    while (rsp_valid !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
      if (lat > 60) begin
        to = 1'b1;
        return;
      end
    end
    s = rsp_sum; c = rsp_cout; id = rsp_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1; req1_valid = 1;
    rsp_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (req0_ready !== 0 || req1_ready !== 0 || rsp_valid !== 0) begin
      failures++;
      $display("FAIL reset_ctl: r0=%b r1=%b v=%b want 0 0 0",
               req0_ready, req1_ready, rsp_valid);
    end
    checks++;
    if (rsp_sum !== 16'h0 || rsp_cout !== 0 || rsp_id !== 0) begin
      failures++;
      $display("FAIL reset_rsp: sum=%h c=%b id=%b want 0000 0 0",
               rsp_sum, rsp_cout, rsp_id);
    end
    do_reset();
  endtask

  task automatic test_single_add();
    logic [W-1:0] s; logic c, id; int w, lat; bit t1, t2;
    do_reset();
    issue(0, 16'h1234, 16'h4321, 0, w, t1);
    get_rsp(s, c, id, lat, t2);
    checks++;
    if (t1 || t2 || w != 0 || lat != 5) begin
      failures++;
      $display("FAIL single_timing: wait=%0d lat=%0d to=%b%b want 0 5",
               w, lat, t1, t2);
    end
    checks++;
    if (s !== 16'h5555 || c !== 0 || id !== 0) begin
      failures++;
      $display("FAIL single_sum: %h c=%b id=%b want 5555 0 0", s, c, id);
    end
  endtask

  task automatic test_carry_ripple();
    logic [W-1:0] s; logic c, id; int w, lat; bit t1, t2;
    issue(1, 16'hFFFF, 16'h0001, 0, w, t1);
    get_rsp(s, c, id, lat, t2);
    checks++;
    if (t1 || t2 || s !== 16'h0000 || c !== 1 || id !== 1) begin
      failures++;
      $display("FAIL ripple1: %h c=%b id=%b want 0000 1 1", s, c, id);
    end
    issue(1, 16'hFFFF, 16'hFFFF, 1, w, t1);
    get_rsp(s, c, id, lat, t2);
    checks++;
    if (t1 || t2 || s !== 16'hFFFF || c !== 1 || id !== 1) begin
      failures++;
      $display("FAIL ripple2: %h c=%b id=%b want FFFF 1 1", s, c, id);
    end
  endtask

  task automatic test_contention();
    logic [W-1:0] s; logic c, id; int lat, n; bit t, g, overlap;
    logic [16:0] exp_v [4];
    exp_v[0] = 17'h00303; exp_v[1] = 17'h00F10;
    exp_v[2] = 17'h03334; exp_v[3] = 17'h10000;
    do_reset();
    overlap = 0;
    req0_valid = 1; req0_a = 16'h0101; req0_b = 16'h0202; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h0A0A; req1_b = 16'h0505; req1_cin = 1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (req0_ready !== 1 && req1_ready !== 1 && n < 60) begin
        @(posedge clk); #2; n++;
      end
      if (req0_ready === 1 && req1_ready === 1) overlap = 1;
      g = req1_ready;
      checks++;
      if (n >= 60 || g !== k[0]) begin
        failures++;
        $display("FAIL contend_grant%0d: got %b want %b", k, g, k[0]);
      end
      @(posedge clk); #1;
      if (k >= 2) begin
        if (g) req1_valid = 0; else req0_valid = 0;
      end else if (g) begin
        req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 0;
      end else begin
        req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1;
      end
      get_rsp(s, c, id, lat, t);
      checks++;
      if (t || {c, s} !== exp_v[k] || id !== k[0]) begin
        failures++;
        $display("FAIL contend_rsp%0d: %h id=%b want %h id=%b",
                 k, {c, s}, id, exp_v[k], k[0]);
      end
    end
    checks++;
    if (overlap) begin
      failures++;
      $display("FAIL contend_overlap: both readies high");
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s; logic c, id; int w, lat; bit t1, t2, bad;
    bad = 0;
    rsp_ready = 0;
    issue(0, 16'h00FF, 16'h0F01, 1, w, t1);
    req1_valid = 1; req1_a = 16'h2000; req1_b = 16'h3000; req1_cin = 0;
    lat = 1;
    while (rsp_valid !== 1 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (t1 || lat != 5) begin
      failures++;
      $display("FAIL bp_latency: %0d want 5", lat);
    end
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1 || rsp_sum !== 16'h1001 ||
          rsp_cout !== 0 || rsp_id !== 0 ||
          req0_ready !== 0 || req1_ready !== 0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold: v=%b sum=%h r1=%b want 1 1001 0",
               rsp_valid, rsp_sum, req1_ready);
    end
    rsp_ready = 1;
    #1;
    checks++;
    if (req1_ready !== 0) begin
      failures++;
      $display("FAIL bp_ready_dep: r1=%b want 0", req1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (req1_ready !== 1 || rsp_valid !== 0) begin
      failures++;
      $display("FAIL bp_release: r1=%b v=%b want 1 0",
               req1_ready, rsp_valid);
    end
    @(posedge clk); #1;
    req1_valid = 0;
    get_rsp(s, c, id, lat, t2);
    checks++;
    if (t2 || lat != 5 || s !== 16'h5000 || c !== 0 || id !== 1) begin
      failures++;
      $display("FAIL bp_req1: %h c=%b id=%b lat=%0d want 5000 0 1 5",
               s, c, id, lat);
    end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] s; logic c, id; int w, lat; bit t1, t2, seen;
    issue(0, 16'hABCD, 16'h1111, 1, w, t1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 0 || rsp_sum !== 16'h0 || rsp_cout !== 0) begin
      failures++;
      $display("FAIL midrst_clear: v=%b sum=%h c=%b want 0 0000 0",
               rsp_valid, rsp_sum, rsp_cout);
    end
    rst = 0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid !== 0) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midrst_ghost: response after reset");
    end
    issue(0, 16'h7777, 16'h8889, 0, w, t1);
    get_rsp(s, c, id, lat, t2);
    checks++;
    if (t1 || t2 || w != 0 || lat != 5 ||
        s !== 16'h0000 || c !== 1 || id !== 0) begin
      failures++;
      $display("FAIL midrst_after: %h c=%b id=%b w=%0d lat=%0d",
               s, c, id, w, lat);
    end
  endtask

  task automatic test_random();
    logic [17:0] q[$];
    logic [17:0] e;
    logic [16:0] r;
    bit p0, p1, lastg, g, eg;
    int issued, resp, cyc;
    do_reset();
    p0 = 0; p1 = 0; lastg = 1;
    issued = 0; resp = 0; cyc = 0;
    while (resp < 1000 && cyc < 40000) begin
      rsp_ready = 1'($urandom_range(0, 1));
      if (!p0 && issued < 1000 && $urandom_range(0, 1) == 1) begin
        p0 = 1; issued++;
        req0_a = 16'($urandom); req0_b = 16'($urandom);
        req0_cin = 1'($urandom_range(0, 1));
      end
      if (!p1 && issued < 1000 && $urandom_range(0, 1) == 1) begin
        p1 = 1; issued++;
        req1_a = 16'($urandom); req1_b = 16'($urandom);
        req1_cin = 1'($urandom_range(0, 1));
      end
      req0_valid = p0; req1_valid = p1;
      #1;
      if (req0_ready === 1 || req1_ready === 1) begin
        g = req1_ready;
        eg = (p0 && p1) ? ~lastg : p1;
        checks++;
        if (req0_ready === req1_ready || g !== eg) begin
          failures++;
          $display("FAIL rand_grant: r0=%b r1=%b want id %b",
                   req0_ready, req1_ready, eg);
        end
        lastg = g;
        if (g) begin
          r = {1'b0, req1_a} + {1'b0, req1_b} + 17'(req1_cin);
          p1 = 0;
        end else begin
          r = {1'b0, req0_a} + {1'b0, req0_b} + 17'(req0_cin);
          p0 = 0;
        end
        q.push_back({g, r});
      end
      if (rsp_valid === 1 && rsp_ready === 1) begin
        resp++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_rsp: unexpected response");
        end else begin
          e = q.pop_front();
          if ({rsp_id, rsp_cout, rsp_sum} !== e) begin
            failures++;
            $display("FAIL rand_rsp: got %h want %h",
                     {rsp_id, rsp_cout, rsp_sum}, e);
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (resp != 1000 || q.size() != 0) begin
      failures++;
      $display("FAIL rand_done: resp=%0d left=%0d want 1000 0",
               resp, q.size());
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_add();
    test_carry_ripple();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
